// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared types for the two-port DRAM arbiter.
//   state_t : arbiter FSM encoding
//   PORT_I  : instruction-fetch port index, PORT_D : data port index
//   op_t    : operands latched at grant time
package dram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
  } op_t;

endpackage

// File: rtl/dram_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin picker.
//   req   in  2  request vector (bit N = port N)
//   ptr   in  1  port favoured when both request
//   grant out 2  one-hot grant, 0 when no request
// Pointer update is owned by the parent FSM.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares a single-port 32-bit memory between the fetch port (0)
// and the data port (1). Round-robin grant, operand latch, LATENCY wait cycles,
// one access cycle, then a one-cycle registered completion.
//   clk, rst (async active-low)
//   reqN/wrN/addrN/wdataN      in   port requests and operands
//   gntN/doneN/rdataN/errN     out  grant pulse, completion pulse and results
//   createdump                 in   dump request, held pending until idle
//   mem_*                      memory interface; mem_enable only in ACCESS
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int unsigned LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  input  logic        createdump,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  input  logic        mem_err,
  output logic        mem_createdump
);

  localparam bit         HAS_WAIT = (LATENCY > 0);
  localparam logic [3:0] LAT_LOAD = HAS_WAIT ? 4'(LATENCY - 1) : 4'd0;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        ptr;        // 1 = port 1 favoured on contention
  logic        dump_pend;
  logic        owner;
  op_t         op_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [1:0]  grant;
  logic        idle, take, in_access, in_done;

  rr_arb2 u_rr (
    .req   ({req1, req0}),
    .ptr   (ptr),
    .grant (grant)
  );

  assign idle      = (state == IDLE);
  assign in_access = (state == ACCESS);
  assign in_done   = (state == DONE);
  assign take      = idle && (req0 || req1);

  // Grants and dump strobe are combinational on req; gate with rst so every
  // output reads 0 while reset is held.
  always_comb begin
    gnt0           = rst && idle && grant[0];
    gnt1           = rst && idle && grant[1];
    mem_createdump = rst && idle && dump_pend && !req0 && !req1;
    mem_enable     = in_access;
    mem_wr         = in_access && op_q.wr;
    mem_addr       = in_access ? op_q.addr : 16'h0;
    mem_data_in    = (in_access && op_q.wr) ? op_q.wdata : 32'h0;
    done0          = in_done && (owner == PORT_I);
    done1          = in_done && (owner == PORT_D);
    rdata0         = done0 ? rdata_q : 32'h0;
    rdata1         = done1 ? rdata_q : 32'h0;
    err0           = done0 && err_q;
    err1           = done1 && err_q;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = HAS_WAIT ? WAIT : ACCESS;
      WAIT:    if (cnt == 4'd0) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ptr       <= 1'b1;
      dump_pend <= 1'b0;
      owner     <= PORT_I;
      op_q      <= '0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        owner <= grant[1];
        op_q  <= grant[1] ? op_t'{wr1, addr1, wdata1} : op_t'{wr0, addr0, wdata0};
        ptr   <= ~grant[1];  // favour the other port next time
        cnt   <= LAT_LOAD;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (in_access) begin
        rdata_q <= op_q.wr ? 32'h0 : mem_data_out;
        err_q   <= mem_err;
      end
      if (createdump)          dump_pend <= 1'b1;
      else if (mem_createdump) dump_pend <= 1'b0;
    end
  end

endmodule
